// File: rtl/counter_scan_pkg.sv
// Shared constants for the CTUD counter-bank scan sequencer.
// Optional CV readback is enabled by defining COUNTER_SCAN_CV_READ_EN.
package counter_scan_pkg;

  localparam int CNT_IDX_LSB = 3;

  // Register offsets inside one counter's 8-word window
  localparam logic [2:0] OFF_CU = 3'd0;
  localparam logic [2:0] OFF_CD = 3'd1;
  localparam logic [2:0] OFF_R  = 3'd2;
  localparam logic [2:0] OFF_LD = 3'd3;
  localparam logic [2:0] OFF_CV = 3'd5;
  localparam logic [2:0] OFF_QD = 3'd6;
  localparam logic [2:0] OFF_QU = 3'd7;

  // Per-counter op order
  localparam logic [2:0] OP_CU = 3'd0;
  localparam logic [2:0] OP_CD = 3'd1;
  localparam logic [2:0] OP_R  = 3'd2;
  localparam logic [2:0] OP_LD = 3'd3;
  localparam logic [2:0] OP_QU = 3'd4;
  localparam logic [2:0] OP_QD = 3'd5;
  localparam logic [2:0] OP_CV = 3'd6;

`ifdef COUNTER_SCAN_CV_READ_EN
  localparam logic [2:0] LAST_OP = OP_CV;
`else
  localparam logic [2:0] LAST_OP = OP_QD;
`endif

  typedef enum logic [1:0] {
    SC_IDLE = 2'd0,
    SC_SCAN = 2'd1,
    SC_DONE = 2'd2
  } scan_state_e;

  typedef enum logic [1:0] {
    XF_IDLE   = 2'd0,
    XF_SETUP  = 2'd1,
    XF_ACCESS = 2'd2
  } xfer_state_e;

  function automatic logic [2:0] op_offset(input logic [2:0] op);
    logic [2:0] off;
    off = OFF_CU;
    case (op)
      OP_CU:   off = OFF_CU;
      OP_CD:   off = OFF_CD;
      OP_R:    off = OFF_R;
      OP_LD:   off = OFF_LD;
      OP_QU:   off = OFF_QU;
      OP_QD:   off = OFF_QD;
      OP_CV:   off = OFF_CV;
      default: off = OFF_CU;
    endcase
    return off;
  endfunction

  function automatic logic op_is_write(input logic [2:0] op);
    return (op < OP_QU);
  endfunction

endpackage

// File: rtl/counter_scan_sequencer_apb_master_xfer.sv
// Single APB transaction engine: SETUP, ACCESS, wait-state hold; a new request
// may be accepted on the completing ACCESS cycle so transfers chain via SETUP.
module apb_master_xfer
  import counter_scan_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              write_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              xfer_done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  xfer_state_e       state_q, state_d;
  logic              load;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    xfer_done_o = (state_q == XF_ACCESS) && pready_i;
    case (state_q)
      XF_IDLE: begin
        if (req_i) begin
          state_d = XF_SETUP;
          load    = 1'b1;
        end
      end
      XF_SETUP: state_d = XF_ACCESS;
      XF_ACCESS: begin
        if (pready_i) begin
          if (req_i) begin
            state_d = XF_SETUP;
            load    = 1'b1;
          end else begin
            state_d = XF_IDLE;
          end
        end
      end
      default: state_d = XF_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= XF_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        addr_q  <= addr_i;
        write_q <= write_i;
        wdata_q <= wdata_i;
      end else if (state_d == XF_IDLE) begin
        addr_q  <= '0;
        write_q <= 1'b0;
        wdata_q <= '0;
      end
    end
  end

  assign rdata_o   = prdata_i;
  assign psel_o    = (state_q != XF_IDLE);
  assign penable_o = (state_q == XF_ACCESS);
  assign pwrite_o  = write_q;
  assign paddr_o   = addr_q;
  assign pwdata_o  = wdata_q;

endmodule

// File: rtl/counter_scan_sequencer.sv
// Per-scan APB walker over the CTUD counter bank; latches the input image,
// issues per-counter ops, publishes QU/QD atomically. Option: COUNTER_SCAN_CV_READ_EN.
module counter_scan_sequencer
  import counter_scan_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int CNT_BITS = 8,
  parameter int NUM_CNT  = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                start,
  input  logic [NUM_CNT-1:0]  cu_in,
  input  logic [NUM_CNT-1:0]  cd_in,
  input  logic [NUM_CNT-1:0]  r_in,
  input  logic [NUM_CNT-1:0]  ld_in,
  output logic [NUM_CNT-1:0]  qu_out,
  output logic [NUM_CNT-1:0]  qd_out,
  output logic                busy,
  output logic                done,
  output logic                overrun,
`ifdef COUNTER_SCAN_CV_READ_EN
  output logic                cv_valid,
  output logic [CNT_BITS-1:0] cv_idx,
  output logic [DATA_W-1:0]   cv_data,
`endif
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY
);

  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(NUM_CNT - 1);

  scan_state_e         state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [CNT_BITS-1:0] idx_q, idx_d;
  logic [NUM_CNT-1:0]  cu_s, cd_s, r_s, ld_s;
  logic [NUM_CNT-1:0]  qu_s, qu_s_d, qd_s, qd_s_d;
  logic [NUM_CNT-1:0]  qu_out_q, qd_out_q, sel;
  logic                busy_q, done_q, overrun_q;
  logic                req, req_write, wbit, img_live, enter_done;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                xfer_done;
  logic [DATA_W-1:0]   xfer_rdata;

  function automatic logic bit_at(input logic [NUM_CNT-1:0] v, input logic [CNT_BITS-1:0] i);
    logic [NUM_CNT-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    req     = 1'b0;
    case (state_q)
      SC_IDLE: begin
        if (start) begin
          state_d = SC_SCAN;
          op_d    = '0;
          idx_d   = '0;
          req     = 1'b1;
        end
      end
      SC_SCAN: begin
        if (xfer_done) begin
          if (op_q != LAST_OP) begin
            op_d = op_q + 3'd1;
            req  = 1'b1;
          end else if (idx_q != LAST_IDX) begin
            op_d  = '0;
            idx_d = idx_q + CNT_BITS'(1);
            req   = 1'b1;
          end else begin
            op_d    = '0;
            idx_d   = '0;
            state_d = SC_DONE;
          end
        end
      end
      SC_DONE: state_d = SC_IDLE;
      default: state_d = SC_IDLE;
    endcase
  end

  // The first op of a scan is issued in the same cycle the image is latched,
  // so its write bit comes straight from the input pins.
  always_comb begin
    img_live = (state_q == SC_IDLE);
    wbit     = 1'b0;
    case (op_d)
      OP_CU:   wbit = bit_at(img_live ? cu_in : cu_s, idx_d);
      OP_CD:   wbit = bit_at(img_live ? cd_in : cd_s, idx_d);
      OP_R:    wbit = bit_at(img_live ? r_in  : r_s,  idx_d);
      OP_LD:   wbit = bit_at(img_live ? ld_in : ld_s, idx_d);
      default: wbit = 1'b0;
    endcase
    req_write = op_is_write(op_d);
    req_wdata = DATA_W'(wbit);
    req_addr  = (ADDR_W'(idx_d) << CNT_IDX_LSB) | ADDR_W'(op_offset(op_d));

    sel    = NUM_CNT'(1) << idx_q;
    qu_s_d = qu_s;
    qd_s_d = qd_s;
    if (state_q == SC_IDLE && start) begin
      qu_s_d = '0;
      qd_s_d = '0;
    end else if (state_q == SC_SCAN && xfer_done) begin
      if (op_q == OP_QU) qu_s_d = (qu_s & ~sel) | (xfer_rdata[0] ? sel : '0);
      if (op_q == OP_QD) qd_s_d = (qd_s & ~sel) | (xfer_rdata[0] ? sel : '0);
    end
    enter_done = (state_q == SC_SCAN) && (state_d == SC_DONE);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= SC_IDLE;
      op_q      <= '0;
      idx_q     <= '0;
      cu_s      <= '0;
      cd_s      <= '0;
      r_s       <= '0;
      ld_s      <= '0;
      qu_s      <= '0;
      qd_s      <= '0;
      qu_out_q  <= '0;
      qd_out_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      qu_s      <= qu_s_d;
      qd_s      <= qd_s_d;
      busy_q    <= (state_d != SC_IDLE);
      done_q    <= enter_done;
      overrun_q <= start && (state_q != SC_IDLE);
      if (state_q == SC_IDLE && start) begin
        cu_s <= cu_in;
        cd_s <= cd_in;
        r_s  <= r_in;
        ld_s <= ld_in;
      end
      if (enter_done) begin
        qu_out_q <= qu_s_d;
        qd_out_q <= qd_s_d;
      end
    end
  end

`ifdef COUNTER_SCAN_CV_READ_EN
  logic                cv_valid_q;
  logic [CNT_BITS-1:0] cv_idx_q;
  logic [DATA_W-1:0]   cv_data_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cv_valid_q <= 1'b0;
      cv_idx_q   <= '0;
      cv_data_q  <= '0;
    end else begin
      cv_valid_q <= (state_q == SC_SCAN) && xfer_done && (op_q == OP_CV);
      if ((state_q == SC_SCAN) && xfer_done && (op_q == OP_CV)) begin
        cv_idx_q  <= idx_q;
        cv_data_q <= xfer_rdata;
      end
    end
  end

  assign cv_valid = cv_valid_q;
  assign cv_idx   = cv_idx_q;
  assign cv_data  = cv_data_q;
`else
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^xfer_rdata[DATA_W-1:1];
`endif

  apb_master_xfer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_xfer (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .req_i       (req),
    .addr_i      (req_addr),
    .write_i     (req_write),
    .wdata_i     (req_wdata),
    .xfer_done_o (xfer_done),
    .rdata_o     (xfer_rdata),
    .psel_o      (PSEL),
    .penable_o   (PENABLE),
    .pwrite_o    (PWRITE),
    .paddr_o     (PADDR),
    .pwdata_o    (PWDATA),
    .prdata_i    (PRDATA),
    .pready_i    (PREADY)
  );

  assign qu_out  = qu_out_q;
  assign qd_out  = qd_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: doc/counter_scan_sequencer.md
# counter_scan_sequencer

APB master that drives the IEC 61131 CTUD counter bank once per PLC scan. On each `start` it latches the counter input image (CU/CD/R/LD per counter) and walks counters 0..NUM_CNT-1 in order, issuing the bank's write/read transactions for each one. It then publishes the QU/QD output image atomically. It sits between the PLC scan controller and the counter bank's APB slave port, and is the bank's only master.

## Interface
Parameters:
- `DATA_W`, default 32: APB data width; must match the counter bank.
- `ADDR_W`, default 16: APB address width.
- `CNT_BITS`, default 8: counter index width; the index occupies `PADDR[CNT_BITS+2:3]`.
- `NUM_CNT`, default 16: number of counters scanned; must satisfy 1 ≤ NUM_CNT ≤ 2**CNT_BITS.

Ports (clock and reset are fixed: one clock; reset is asynchronous and active-high):
- `PCLK` in 1: single clock.
- `PRESET` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle scan request.
- `cu_in`, `cd_in`, `r_in`, `ld_in` in NUM_CNT each: input image; bit i belongs to counter i.
- `qu_out`, `qd_out` out NUM_CNT each: output image, updated at end of scan.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse when the scan completes.
- `overrun` out 1: one-cycle pulse when `start` arrives while `busy` is high.
- `PSEL`, `PENABLE`, `PWRITE` out 1 each: APB master controls.
- `PADDR` out ADDR_W: APB address.
- `PWDATA` out DATA_W: APB write data.
- `PRDATA` in DATA_W: APB read data; only bit 0 is used, except in CV mode.
- `PREADY` in 1: APB ready.

## Operation
- Reset values: all outputs are 0. `qu_out` and `qd_out` are 0. The FSM is in IDLE and the counter index is 0.
- Per-counter op sequence. Offset is `PADDR[2:0]`:
  - op0: write CU, offset 0, `PWDATA = {0, cu_in[i]}`.
  - op1: write CD, offset 1.
  - op2: write R, offset 2.
  - op3: write LD, offset 3.
  - op4: read QU, offset 7.
  - op5: read QD, offset 6.
- `PADDR = {0, i[CNT_BITS-1:0], op_offset}`. `PWDATA` is 0 during reads.
- Input image is latched into shadow registers on accepted `start`. Changes to `cu_in` etc. during the scan have no effect.
- QU/QD read bits (`PRDATA[0]` on the access cycle with `PREADY=1`) go to shadow registers. These are copied to `qu_out`/`qd_out` in the DONE state.
- FSM states:
  - IDLE: waits for `start`.
  - SETUP: `PSEL=1`, `PENABLE=0`.
  - ACCESS: `PSEL=1`, `PENABLE=1`; holds while `PREADY=0`.
  - DONE: publishes the image and pulses `done`.
- Transitions:
  - IDLE→SETUP on `start`.
  - SETUP→ACCESS always.
  - ACCESS→SETUP on `PREADY` when the transaction is not the last op of the last counter; the op and index advance.
  - ACCESS→DONE on `PREADY` for the last op of counter NUM_CNT-1.
  - DONE→IDLE always.
- APB rules: `PADDR`, `PWRITE` and `PWDATA` are stable from SETUP through the completing ACCESS cycle. `PSEL` drops to 0 only in DONE/IDLE; there is no back-to-back without a SETUP.
- `start` while not IDLE: ignored and `overrun` pulses. `start` in the DONE cycle also counts as overrun.
- Reset mid-scan: the bus is released immediately (async). Shadow and output images clear, and no `done` pulse occurs.
- Index wrap: the index never exceeds NUM_CNT-1 and resets to 0 at DONE.

## Timing
- Registered outputs only; no combinational path from `PREADY`/`PRDATA` to outputs.
- `start` sampled at edge 0 → `busy=1` and SETUP visible after edge 0.
- Each transaction takes 2 + W cycles, where W is the number of `PREADY=0` access cycles.
- Zero-wait scan: 12·NUM_CNT cycles of bus activity plus 1 DONE cycle. `done` and the new `qu_out`/`qd_out` appear together, and `busy` falls after DONE.
- Minimum `start`-to-`start` spacing: 12·NUM_CNT+2 cycles.

## Configuration
- Macro `COUNTER_SCAN_CV_READ_EN`.
- Defined:
  - Adds op6, a read of CV at offset 5, after op5 for each counter. A zero-wait scan then takes 14·NUM_CNT+1 cycles.
  - Adds outputs `cv_valid` (1), `cv_idx` (CNT_BITS) and `cv_data` (DATA_W).
  - `cv_valid` pulses one cycle after each CV read completes, carrying the index and `PRDATA`. All three outputs reset to 0.
- Undefined: no op6, no extra ports, and offset 5 is never issued.

## Structure
- Shared package/include `counter_scan_pkg`:
  - op offset constants: CU=0, CD=1, R=2, LD=3, CV=5, QD=6, QU=7;
  - FSM state encoding;
  - `CNT_IDX_LSB=3`.
- One natural sub-module, `apb_master_xfer`: a single-transaction engine (SETUP/ACCESS/wait handling, returns `rdata` + `xfer_done`). The sequencer proper holds the op/index counters, shadow images and DONE publishing.

## Test plan
- Reset: assert `PRESET` mid-cycle → all outputs are 0 asynchronously and `PSEL` is 0 with no clock edge.
- NUM_CNT=2, zero wait, `cu_in=2'b01`, slave returns `PRDATA[0]=1` for QU of counter 1 only:
  - PADDR sequence 0x000,0x001,0x002,0x003,0x007,0x006,0x008,…,0x00E;
  - `done` at cycle 25;
  - `qu_out=2'b10`.
- Wait states: `PREADY=0` for 3 cycles on op2 of counter 0 → ACCESS held with stable `PADDR=0x002` and `PWDATA`; the scan extends by exactly 3 cycles.
- `start` pulsed 5 cycles into a scan → `overrun=1` for one cycle; the scan is unchanged, only one `done`, and the latched image is the pre-start one.
- Reset at counter 1 op4 → bus idle, `qu_out=0`, no `done`; a subsequent `start` performs a full scan from index 0.
- With `COUNTER_SCAN_CV_READ_EN`, NUM_CNT=2, CV values 5 and 0xFFFFFFFF → two `cv_valid` pulses with `cv_idx` 0/1 and matching `cv_data`; a zero-wait scan takes 29 cycles.
